// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared state enum, width helper and default sizes for mvm_bitserial
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mvm_state_e;

  localparam int DEF_XBAR_SIZE = 16;
  localparam int DEF_IN_BITS   = 16;
  localparam int DEF_WT_BITS   = 16;
  localparam int DEF_OUT_BITS  = 32;

  // Full-precision accumulator width: product bits plus headroom for N summed terms.
  function automatic int acc_width(input int in_bits, input int wt_bits, input int xbar_size);
    return in_bits + wt_bits + $clog2(xbar_size);
  endfunction

endpackage

// File: rtl/mvm_column_acc.sv
// rtl/mvm_column_acc.sv - one crossbar column: masked weight sum, bit-plane shift, accumulator
module mvm_column_acc
  import mvm_pkg::*;
#(
  parameter int XBAR_SIZE = 4,
  parameter int WT_BITS   = 4,
  parameter int ACC_BITS  = 10,
  parameter int SH_W      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr,
  input  logic                                en,
  input  logic [XBAR_SIZE-1:0]                x_bits,
  input  logic [XBAR_SIZE-1:0][WT_BITS-1:0]   w_col,
  input  logic [SH_W-1:0]                     shift,
  output logic [ACC_BITS-1:0]                 acc
);

  logic [ACC_BITS-1:0] partial;
  logic [ACC_BITS-1:0] acc_d;
  logic [ACC_BITS-1:0] acc_q;

  // Sum of the weights whose row input bit is set in the current bit-plane.
  always_comb begin
    partial = '0;
    for (int i = 0; i < XBAR_SIZE; i++) begin
      if (x_bits[i]) begin
        partial = partial + ACC_BITS'(w_col[i]);
      end
    end
  end

  // Clear on a new operation, otherwise add the plane sum weighted by its bit position.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + (partial << shift);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mvm_bitserial.sv
// rtl/mvm_bitserial.sv - bit-serial crossbar MVM y = W^T x; MVM_OUT_SAT_EN selects saturating outputs and sat_flag
module mvm_bitserial
  import mvm_pkg::*;
#(
  parameter int XBAR_SIZE = DEF_XBAR_SIZE,
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int WT_BITS   = DEF_WT_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  localparam int ROW_W    = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 reset_wt,
  input  logic                                 mvm_start,
  input  logic                                 prog_wt,
  input  logic [ROW_W-1:0]                     wt_row,
  input  logic [XBAR_SIZE-1:0][WT_BITS-1:0]    wr_weight_row,
  input  logic [XBAR_SIZE-1:0][IN_BITS-1:0]    xbar_input,
  output logic                                 mvm_busy,
  output logic                                 mvm_done,
  output logic                                 prog_err,
  output logic [XBAR_SIZE-1:0][OUT_BITS-1:0]   xbar_output
`ifdef MVM_OUT_SAT_EN
  ,
  output logic                                 sat_flag
`endif
);

  localparam int ACC_BITS = acc_width(IN_BITS, WT_BITS, XBAR_SIZE);
  localparam int CNT_W    = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_BITS - 1);

  mvm_state_e state_d, state_q;
  logic [CNT_W-1:0]                            bit_d, bit_q;
  logic [XBAR_SIZE-1:0][IN_BITS-1:0]           x_d, x_q;
  logic [XBAR_SIZE-1:0][XBAR_SIZE-1:0][WT_BITS-1:0] wt_d, wt_q;
  logic [XBAR_SIZE-1:0][OUT_BITS-1:0]          xbar_d, xbar_q;
  logic                                        done_d, done_q;
  logic                                        prog_err_d, prog_err_q;
  logic                                        start_ok;
  logic                                        acc_clr;
  logic                                        acc_en;
  logic [XBAR_SIZE-1:0]                        x_bits;
  logic [XBAR_SIZE-1:0][ACC_BITS-1:0]          acc;
  logic [XBAR_SIZE-1:0]                        acc_ovf;
  logic [XBAR_SIZE-1:0][OUT_BITS-1:0]          reduced;

  // The done cycle is already IDLE, so a start there is masked explicitly.
  assign start_ok = (state_q == IDLE) && mvm_start && !done_q;

  // Current bit-plane is the LSB of each shifting input element.
  always_comb begin
    x_bits = '0;
    for (int i = 0; i < XBAR_SIZE; i++) begin
      x_bits[i] = x_q[i][0];
    end
  end

  for (genvar j = 0; j < XBAR_SIZE; j++) begin : g_col
    logic [XBAR_SIZE-1:0][WT_BITS-1:0] w_col;

    // Gather column j of the weight array.
    always_comb begin
      w_col = '0;
      for (int i = 0; i < XBAR_SIZE; i++) begin
        w_col[i] = wt_q[i][j];
      end
    end

    mvm_column_acc #(
      .XBAR_SIZE (XBAR_SIZE),
      .WT_BITS   (WT_BITS),
      .ACC_BITS  (ACC_BITS),
      .SH_W      (CNT_W)
    ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .en     (acc_en),
      .x_bits (x_bits),
      .w_col  (w_col),
      .shift  (bit_q),
      .acc    (acc[j])
    );

    if (OUT_BITS < ACC_BITS) begin : g_ovf
      assign acc_ovf[j] = |acc[j][ACC_BITS-1:OUT_BITS];
    end else begin : g_no_ovf
      assign acc_ovf[j] = 1'b0;
    end
  end

`ifdef MVM_OUT_SAT_EN
  // Clamp any column that does not fit the output width.
  always_comb begin
    reduced = '0;
    for (int j = 0; j < XBAR_SIZE; j++) begin
      reduced[j] = acc_ovf[j] ? {OUT_BITS{1'b1}} : acc[j][OUT_BITS-1:0];
    end
  end
`else
  logic unused_acc_ovf;
  assign unused_acc_ovf = |acc_ovf;

  // Keep the low output bits; overflow wraps.
  always_comb begin
    reduced = '0;
    for (int j = 0; j < XBAR_SIZE; j++) begin
      reduced[j] = acc[j][OUT_BITS-1:0];
    end
  end
`endif

  // Next-state, datapath control and weight-write decode.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    x_d        = x_q;
    xbar_d     = xbar_q;
    done_d     = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    prog_err_d = prog_wt && (state_q == COMPUTE);
    wt_d       = wt_q;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = COMPUTE;
          x_d     = xbar_input;
          bit_d   = '0;
          acc_clr = 1'b1;
        end
      end
      COMPUTE: begin
        acc_en = 1'b1;
        for (int i = 0; i < XBAR_SIZE; i++) begin
          x_d[i] = x_q[i] >> 1;
        end
        bit_d = bit_q + CNT_W'(1);
        if (bit_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        xbar_d  = reduced;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset_wt) begin
      wt_d = '0;
    end else if (prog_wt && (state_q != COMPUTE) && (int'(wt_row) < XBAR_SIZE)) begin
      wt_d[wt_row] = wr_weight_row;
    end
  end

  // Control and output registers; reset leaves weights alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      x_q        <= '0;
      xbar_q     <= '0;
      done_q     <= 1'b0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      x_q        <= x_d;
      xbar_q     <= xbar_d;
      done_q     <= done_d;
      prog_err_q <= prog_err_d;
    end
  end

  // Weight storage, cleared only by reset_wt.
  always_ff @(posedge clk) begin
    wt_q <= wt_d;
  end

`ifdef MVM_OUT_SAT_EN
  logic sat_d, sat_q;

  // Sticky saturation flag, cleared when a new operation starts.
  always_comb begin
    sat_d = sat_q;
    if (start_ok) begin
      sat_d = 1'b0;
    end else if ((state_q == DONE) && (|acc_ovf)) begin
      sat_d = 1'b1;
    end
  end

  // Saturation flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`endif

  assign mvm_busy    = (state_q == COMPUTE);
  assign mvm_done    = done_q;
  assign prog_err    = prog_err_q;
  assign xbar_output = xbar_q;

endmodule

// File: tb/tb_mvm_bitserial.sv
// tb/tb_mvm_bitserial.sv - directed table-driven bench for mvm_bitserial (N=4, IN=4, WT=4, OUT=16 and OUT=8)
module tb_mvm_bitserial;

  logic              clk;
  logic              reset;
  logic              reset_wt;
  logic              mvm_start;
  logic              prog_wt;
  logic [1:0]        wt_row;
  logic [3:0][3:0]   wr_weight_row;
  logic [3:0][3:0]   xbar_input;
  logic              busy16, done16, perr16;
  logic              busy8, done8, perr8;
  logic [3:0][15:0]  out16;
  logic [3:0][7:0]   out8;
`ifdef MVM_OUT_SAT_EN
  logic              sat16, sat8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mvm_bitserial #(.XBAR_SIZE(4), .IN_BITS(4), .WT_BITS(4), .OUT_BITS(16)) dut16 (
    .clk           (clk),
    .reset         (reset),
    .reset_wt      (reset_wt),
    .mvm_start     (mvm_start),
    .prog_wt       (prog_wt),
    .wt_row        (wt_row),
    .wr_weight_row (wr_weight_row),
    .xbar_input    (xbar_input),
    .mvm_busy      (busy16),
    .mvm_done      (done16),
    .prog_err      (perr16),
    .xbar_output   (out16)
`ifdef MVM_OUT_SAT_EN
    ,
    .sat_flag      (sat16)
`endif
  );

  mvm_bitserial #(.XBAR_SIZE(4), .IN_BITS(4), .WT_BITS(4), .OUT_BITS(8)) dut8 (
    .clk           (clk),
    .reset         (reset),
    .reset_wt      (reset_wt),
    .mvm_start     (mvm_start),
    .prog_wt       (prog_wt),
    .wt_row        (wt_row),
    .wr_weight_row (wr_weight_row),
    .xbar_input    (xbar_input),
    .mvm_busy      (busy8),
    .mvm_done      (done8),
    .prog_err      (perr8),
    .xbar_output   (out8)
`ifdef MVM_OUT_SAT_EN
    ,
    .sat_flag      (sat8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic prog_row(input int r, input logic [15:0] val);
    prog_wt       = 1'b1;
    wt_row        = 2'(r);
    wr_weight_row = val;
    tick();
    prog_wt = 1'b0;
  endtask

  task automatic prog_identity();
    prog_row(0, 16'h0001);
    prog_row(1, 16'h0010);
    prog_row(2, 16'h0100);
    prog_row(3, 16'h1000);
  endtask

  // mode 0: plain run; 1: weight write + second start during compute; 2: reset at compute cycle 2
  task automatic run_op(input logic [15:0] x, input int mode, input logic [63:0] e16,
                        input logic [31:0] e8, input string tag);
    int busy_cnt;
    int lat;
    busy_cnt   = 0;
    lat        = -1;
    xbar_input = x;
    mvm_start  = 1'b1;
    tick();
    mvm_start  = 1'b0;
    prog_wt    = 1'b0;
    xbar_input = ~x;
    for (int k = 1; k <= 20; k++) begin
      if (busy16) busy_cnt++;
      if (done16) begin
        lat = k;
        break;
      end
      if (mode == 1 && k == 2) begin
        prog_wt       = 1'b1;
        wt_row        = 2'd0;
        wr_weight_row = 16'h000F;
        mvm_start     = 1'b1;
        xbar_input    = 16'hFFFF;
      end
      if (mode == 2 && k == 2) reset = 1'b1;
      tick();
      prog_wt   = 1'b0;
      mvm_start = 1'b0;
      if (mode == 1 && k == 2) chk({tag, "_prog_err_pulse"}, 64'(perr16), 64'd1);
      if (mode == 1 && k == 3) chk({tag, "_prog_err_clear"}, 64'(perr16), 64'd0);
      if (mode == 2 && k == 2) begin
        reset = 1'b0;
        chk({tag, "_busy"}, 64'(busy16), 64'd0);
        chk({tag, "_done"}, 64'(done16), 64'd0);
        chk({tag, "_out16"}, out16, 64'd0);
        chk({tag, "_out8"}, 64'(out8), 64'd0);
        tick();
        chk({tag, "_stay_idle"}, 64'(busy16), 64'd0);
        return;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd6);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    chk({tag, "_out16"}, out16, e16);
    chk({tag, "_out8"}, 64'(out8), 64'(e8));
    mvm_start = 1'b1;
    tick();
    mvm_start = 1'b0;
    chk({tag, "_done_one_cycle"}, 64'(done16), 64'd0);
    chk({tag, "_start_in_done_ignored"}, 64'(busy16), 64'd0);
    chk({tag, "_out_held"}, out16, e16);
  endtask

  typedef struct {
    logic [3:0][15:0] w;
    logic [15:0]      x;
    logic [63:0]      e16;
    logic [31:0]      e8;
    logic             esat8;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [31:0] big8;
`ifdef MVM_OUT_SAT_EN
    big8 = 32'hFFFF_FFFF;
`else
    big8 = 32'h8484_8484;
`endif
    tv[0] = '{w: {16'h1000, 16'h0100, 16'h0010, 16'h0001}, x: 16'h4321,
              e16: 64'h0004_0003_0002_0001, e8: 32'h0403_0201, esat8: 1'b0};
    tv[1] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, x: 16'hFFFF,
              e16: 64'h0384_0384_0384_0384, e8: big8, esat8: 1'b1};
    tv[2] = '{w: {16'h0000, 16'h5555, 16'h0000, 16'h4321}, x: 16'hF293,
              e16: 64'h0016_0013_0010_000D, e8: 32'h1613_100D, esat8: 1'b0};
    tv[3] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, x: 16'h0000,
              e16: 64'h0, e8: 32'h0, esat8: 1'b0};
    tv[4] = '{w: {16'h4321, 16'h0000, 16'h0000, 16'hFFFF}, x: 16'h100F,
              e16: 64'h00E5_00E4_00E3_00E2, e8: 32'hE5E4_E3E2, esat8: 1'b0};

    reset         = 1'b1;
    reset_wt      = 1'b1;
    mvm_start     = 1'b0;
    prog_wt       = 1'b0;
    wt_row        = '0;
    wr_weight_row = '0;
    xbar_input    = '0;
    tick();
    tick();
    reset    = 1'b0;
    reset_wt = 1'b0;
    chk("reset_busy", 64'(busy16), 64'd0);
    chk("reset_done", 64'(done16), 64'd0);
    chk("reset_prog_err", 64'(perr16), 64'd0);
    chk("reset_out16", out16, 64'd0);
    chk("reset_out8", 64'(out8), 64'd0);

    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < 4; r++) prog_row(r, tv[v].w[r]);
      run_op(tv[v].x, 0, tv[v].e16, tv[v].e8, $sformatf("vec%0d", v));
`ifdef MVM_OUT_SAT_EN
      chk($sformatf("vec%0d_sat8", v), 64'(sat8), 64'(tv[v].esat8));
      chk($sformatf("vec%0d_sat16", v), 64'(sat16), 64'd0);
`endif
    end

    prog_identity();
    run_op(16'h4321, 1, 64'h0004_0003_0002_0001, 32'h0403_0201, "prog_busy");
    run_op(16'h4321, 0, 64'h0004_0003_0002_0001, 32'h0403_0201, "wt_unchanged");

    prog_row(0, 16'h1111);
    prog_wt       = 1'b1;
    wt_row        = 2'd0;
    wr_weight_row = 16'h2222;
    run_op(16'h4321, 0, 64'h0006_0005_0004_0002, 32'h0605_0402, "prog_with_start");

    prog_row(0, 16'h0001);
    run_op(16'h4321, 2, 64'h0, 32'h0, "mid_reset");
    run_op(16'h4321, 0, 64'h0004_0003_0002_0001, 32'h0403_0201, "after_reset");

    reset_wt = 1'b1;
    tick();
    reset_wt = 1'b0;
    run_op(16'h7777, 0, 64'h0, 32'h0, "wt_cleared");

    prog_identity();
    reset_wt      = 1'b1;
    prog_wt       = 1'b1;
    wt_row        = 2'd0;
    wr_weight_row = 16'h0001;
    tick();
    reset_wt = 1'b0;
    prog_wt  = 1'b0;
    prog_row(1, 16'h0010);
    prog_row(2, 16'h0100);
    prog_row(3, 16'h1000);
    run_op(16'h4321, 0, 64'h0004_0003_0002_0000, 32'h0403_0200, "reset_wt_wins");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
